// File: rtl/cordic_mul.sv
// Bit-exact signed fixed-point multiplier built on linear-rotation CORDIC.
// One rotation per cycle, a residual correction step, then floor + saturate.
module cordic_mul #(
  parameter int WORD_LENGTH     = 16,
  parameter int FRACTION_LENGTH = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WORD_LENGTH-1:0] multiplicand,
  input  logic [WORD_LENGTH-1:0] multiplier,
  output logic [WORD_LENGTH-1:0] product,
  output logic                   done,
  output logic                   busy,
  output logic                   Error
);

  localparam int N  = WORD_LENGTH;
  localparam int ZW = WORD_LENGTH + 2;
  localparam int YW = 2 * WORD_LENGTH + 2;
  localparam int KW = $clog2(N);

  localparam logic signed [YW-1:0] MAX_P = {{(YW-WORD_LENGTH+1){1'b0}}, {(WORD_LENGTH-1){1'b1}}};
  localparam logic signed [YW-1:0] MIN_N = {{(YW-WORD_LENGTH+1){1'b1}}, {(WORD_LENGTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ROTATE, S_CORRECT, S_DONE} state_t;

  state_t                        state_q, state_d;
  logic signed [WORD_LENGTH-1:0] x_q, x_d;
  logic signed [ZW-1:0]          z_q, z_d;
  logic signed [YW-1:0]          y_q, y_d;
  logic [KW-1:0]                 k_q, k_d;
  logic [WORD_LENGTH-1:0]        prod_q, prod_d;
  logic                          err_q, err_d;
  logic                          done_q, done_d;

  logic signed [YW-1:0]          x_ext;
  logic signed [YW-1:0]          s_k;
  logic signed [ZW-1:0]          w_k;
  logic [KW-1:0]                 shamt;

  // Returns {error, value}: floor by arithmetic shift, then clamp to the word range.
  function automatic logic [WORD_LENGTH:0] sat_floor(input logic signed [YW-1:0] y);
    logic signed [YW-1:0] t;
    t = y >>> FRACTION_LENGTH;
    if (t > MAX_P)      sat_floor = {1'b1, 1'b0, {(WORD_LENGTH-1){1'b1}}};
    else if (t < MIN_N) sat_floor = {1'b1, 1'b1, {(WORD_LENGTH-1){1'b0}}};
    else                sat_floor = {1'b0, t[WORD_LENGTH-1:0]};
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      z_q     <= '0;
      y_q     <= '0;
      k_q     <= '0;
      prod_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      z_q     <= z_d;
      y_q     <= y_d;
      k_q     <= k_d;
      prod_q  <= prod_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // s_k = x * 2^(N-1-k); the Q-format shifts cancel, so it is a plain left shift.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    z_d     = z_q;
    y_d     = y_q;
    k_d     = k_q;
    prod_d  = prod_q;
    err_d   = err_q;
    done_d  = 1'b0;
    x_ext   = {{(YW-WORD_LENGTH){x_q[WORD_LENGTH-1]}}, x_q};
    shamt   = KW'(N-1) - k_q;
    s_k     = x_ext <<< shamt;
    w_k     = ZW'(1) << shamt;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = multiplicand;
          z_d     = {{2{multiplier[WORD_LENGTH-1]}}, multiplier};
          y_d     = '0;
          k_d     = '0;
          state_d = S_ROTATE;
        end
      end
      S_ROTATE: begin
        if (!z_q[ZW-1]) begin
          y_d = y_q + s_k;
          z_d = z_q - w_k;
        end else begin
          y_d = y_q - s_k;
          z_d = z_q + w_k;
        end
        k_d = k_q + 1'b1;
        if (k_q == KW'(N-1)) state_d = S_CORRECT;
      end
      S_CORRECT: begin
        // Weights sum to 2^N-1, leaving a residual of -1, 0 or +1 LSB.
        if (z_q == ZW'(1))   y_d = y_q + x_ext;
        else if (z_q == '1)  y_d = y_q - x_ext;
        state_d = S_DONE;
      end
      S_DONE: begin
        {err_d, prod_d} = sat_floor(y_q);
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign product = prod_q;
  assign Error   = err_q;
  assign done    = done_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_cordic_mul.sv
// Scoreboard bench for cordic_mul: the driver queues expected results, a
// negedge monitor pops one per done pulse and checks value, flag and latency.
module tb_cordic_mul;
  localparam int LAT = 18;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;
  logic [15:0] product;
  logic        done;
  logic        busy;
  logic        Error;

  typedef struct {
    logic [15:0] p;
    logic        e;
    int          t0;
    string       name;
  } exp_t;

  typedef struct {
    logic [15:0] x;
    logic [15:0] z;
    logic [15:0] p;
    logic        e;
    string       name;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;

  cordic_mul #(.WORD_LENGTH(16), .FRACTION_LENGTH(12)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .multiplicand(multiplicand),
    .multiplier(multiplier),
    .product(product),
    .done(done),
    .busy(busy),
    .Error(Error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", {31'b0, done}, 32'd0);
      end else begin
        e = sb.pop_front();
        check({e.name, "_product"}, {16'b0, product}, {16'b0, e.p});
        check({e.name, "_error"}, {31'b0, Error}, {31'b0, e.e});
        check({e.name, "_latency"}, cyc - e.t0, LAT);
      end
    end
  end

  task automatic issue(input logic [15:0] x, input logic [15:0] z,
                       input logic [15:0] ep, input logic ee, input string name);
    exp_t e;
    @(negedge clk);
    multiplicand = x;
    multiplier   = z;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start        = 1'b0;
    multiplicand = ~x;
    multiplier   = ~z;
    e.p = ep; e.e = ee; e.t0 = cyc; e.name = name;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      check({name, "_timeout"}, sb.size(), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  vec_t vecs [11] = '{
    '{16'hE000, 16'h1800, 16'hD000, 1'b0, "neg_pos"},
    '{16'hE000, 16'hE800, 16'h3000, 1'b0, "neg_neg"},
    '{16'h0001, 16'h0001, 16'h0000, 1'b0, "floor_tiny"},
    '{16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, "floor_neg"},
    '{16'h0001, 16'hFFFF, 16'hFFFF, 1'b0, "floor_negz"},
    '{16'h1000, 16'h0002, 16'h0002, 1'b0, "even_z"},
    '{16'h1234, 16'h0000, 16'h0000, 1'b0, "zero_z"},
    '{16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, "sat_pos"},
    '{16'h8000, 16'h8000, 16'h7FFF, 1'b1, "sat_minmin"},
    '{16'h7FFF, 16'h8000, 16'h8000, 1'b1, "sat_neg"},
    '{16'h8000, 16'h1000, 16'h8000, 1'b0, "max_neg"}
  };

  initial begin
    int bc;
    reset        = 1'b0;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (3) @(negedge clk);
    check("rst_product", {16'b0, product}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_error", {31'b0, Error}, 32'd0);
    reset = 1'b1;

    issue(16'h2000, 16'h1800, 16'h3000, 1'b0, "basic");
    bc = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) bc++;
    end
    check("basic_busy_cycles", bc, 32'd18);
    wait_idle("basic");

    foreach (vecs[i]) begin
      issue(vecs[i].x, vecs[i].z, vecs[i].p, vecs[i].e, vecs[i].name);
      wait_idle(vecs[i].name);
    end

    issue(16'h3000, 16'h0800, 16'h1800, 1'b0, "hs_first");
    repeat (5) @(negedge clk);
    multiplicand = 16'h7FFF;
    multiplier   = 16'h7FFF;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(negedge clk);
    issue(16'h0C00, 16'hF000, 16'hF400, 1'b0, "hs_second");
    wait_idle("handshake");

    issue(16'h2000, 16'h2000, 16'h4000, 1'b0, "aborted");
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    #1;
    check("abort_product", {16'b0, product}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_error", {31'b0, Error}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    issue(16'h1000, 16'h0800, 16'h0800, 1'b0, "after_reset");
    wait_idle("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
